// File: rtl/relprime_sequencer.sv
// Sequential relprime controller: finds the smallest m >= 2 with gcd(n, m) == 1
// by repeated-subtraction GCD, behind a start/done request handshake.
module relprime_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [WIDTH-1:0] n,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] TWO   = {{(WIDTH-2){1'b0}}, 2'b10};
   localparam logic [WIDTH-1:0] MAX_M = {WIDTH{1'b1}};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      STEP = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] n_reg_r, n_reg_s;
   logic [WIDTH-1:0] m_r, m_s;
   logic [WIDTH-1:0] a0_r, a0_s;
   logic [WIDTH-1:0] a1_r, a1_s;
   logic [WIDTH-1:0] result_s;
   logic             busy_s, done_s, error_s;

   // Next-state and datapath decode; DONE/ERR accept a new request like IDLE
   // so that a start raised in the done cycle is not lost.
   always_comb begin
      state_s  = state_r;
      n_reg_s  = n_reg_r;
      m_s      = m_r;
      a0_s     = a0_r;
      a1_s     = a1_r;
      result_s = result;

      case (state_r)
         IDLE, DONE, ERR: begin
            if (start) begin
               n_reg_s = n;
               m_s     = TWO;
               if (n == ZERO) begin
                  state_s  = ERR;
                  result_s = ZERO;
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = IDLE;
            end
         end

         LOAD: begin
            a0_s    = n_reg_r;
            a1_s    = m_r;
            state_s = STEP;
         end

         STEP: begin
            if (a0_r > a1_r) begin
               a0_s = a0_r - a1_r;
            end else if (a0_r < a1_r) begin
               a1_s = a1_r - a0_r;
            end else if (a0_r == ONE) begin
               result_s = m_r;
               state_s  = DONE;
            end else if (m_r == MAX_M) begin
               // Candidate space exhausted; cannot happen for n > 0.
               result_s = ZERO;
               state_s  = ERR;
            end else begin
               m_s     = m_r + ONE;
               state_s = LOAD;
            end
         end

         default: begin
            state_s = IDLE;
         end
      endcase

      busy_s  = (state_s == LOAD) || (state_s == STEP);
      done_s  = (state_s == DONE) || (state_s == ERR);
      error_s = (state_s == ERR);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= IDLE;
         n_reg_r <= ZERO;
         m_r     <= ZERO;
         a0_r    <= ZERO;
         a1_r    <= ZERO;
         result  <= ZERO;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         state_r <= state_s;
         n_reg_r <= n_reg_s;
         m_r     <= m_s;
         a0_r    <= a0_s;
         a1_r    <= a1_s;
         result  <= result_s;
         busy    <= busy_s;
         done    <= done_s;
         error   <= error_s;
      end
   end

endmodule
